// File: rtl/bp_be_stall_attribution_counters.sv
// bp_be_stall_attribution_counters
//   Stall attribution for the BlackParrot backend. Per-stage stall-reason
//   vectors are OR-shifted down an attribution pipeline. Every enabled cycle
//   is classified as an instruction commit, one stall reason or unknown, and
//   the matching saturating counter is bumped. Counters are read back through
//   a registered read port.
//
//   Counter map: [0 .. num_reasons_p-1] reasons, [num_reasons_p] instr,
//                [num_reasons_p+1] unknown.
//
//   Optional build macro BP_STALL_ATTR_OVF_EN adds sticky per-counter
//   overflow flags (ovf_o) and their OR (ovf_any_o).

module bp_be_stall_attribution_counters #(
  parameter int num_reasons_p = 22,
  parameter int num_stages_p  = 8,
  parameter int cnt_width_p   = 32,
  parameter int lo_to_hi_p    = 1,
  localparam int num_cnt_lp    = num_reasons_p + 2,
  localparam int addr_width_lp = $clog2(num_cnt_lp)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_li,
  input  logic                                  en_i,
  input  logic                                  freeze_i,
  input  logic                                  clear_i,
  input  logic [num_stages_p*num_reasons_p-1:0] event_i,
  input  logic                                  commit_v_i,
  input  logic                                  rd_v_i,
  input  logic [addr_width_lp-1:0]              rd_addr_i,
  output logic                                  rd_v_o,
  output logic [cnt_width_p-1:0]                rd_data_o
`ifdef BP_STALL_ATTR_OVF_EN
  ,
  output logic [num_cnt_lp-1:0]                 ovf_o,
  output logic                                  ovf_any_o
`endif
);

  typedef logic [num_reasons_p-1:0] reason_vec_t;
  typedef logic [cnt_width_p-1:0]   cnt_t;

  localparam cnt_t cnt_max_lp = {cnt_width_p{1'b1}};
  localparam logic [addr_width_lp-1:0] instr_idx_lp   = addr_width_lp'(num_reasons_p);
  localparam logic [addr_width_lp-1:0] unknown_idx_lp = addr_width_lp'(num_reasons_p + 1);

  // Attribution pipeline and commit alignment register
  reason_vec_t stage_q [num_stages_p];
  reason_vec_t stage_d [num_stages_p];
  logic        commit_q, commit_d;

  // Counter bank and read port
  cnt_t        cnt_q [num_cnt_lp];
  cnt_t        cnt_d [num_cnt_lp];
  logic        rd_v_q, rd_v_d;
  cnt_t        rd_data_q, rd_data_d;

  // Classification helpers
  reason_vec_t               attr_vec;
  logic [addr_width_lp-1:0]  reason_idx;
  logic [addr_width_lp-1:0]  inc_idx;
  logic                      count_en;
  logic [num_cnt_lp-1:0]     inc_hot;
  logic [num_cnt_lp-1:0]     sat;
  cnt_t                      rd_sel;

  // Shift stall events down the pipeline; a reason seen at stage i is OR-ed
  // into everything it passes on the way to the attribution point.
  always_comb begin
    stage_d[0] = event_i[0 +: num_reasons_p];
    for (int i = 1; i < num_stages_p; i++) begin
      stage_d[i] = stage_q[i-1] | event_i[i*num_reasons_p +: num_reasons_p];
    end
    commit_d = commit_v_i;
  end

  assign attr_vec = stage_q[num_stages_p-1];
  assign count_en = en_i & ~freeze_i;

  // Priority-encode the attributed vector; the last match in loop order wins,
  // so the loop direction picks lowest or highest reason index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    reason_idx = '0;
    if (lo_to_hi_p != 0) begin
      for (int j = num_reasons_p - 1; j >= 0; j--) begin
        if (attr_vec[j]) reason_idx = addr_width_lp'(j);
      end
    end else begin
      for (int j = 0; j < num_reasons_p; j++) begin
        if (attr_vec[j]) reason_idx = addr_width_lp'(j);
      end
    end
  end

  // Pick the single counter for this cycle: commit beats stall beats unknown
  always_comb begin
    if (commit_q)       inc_idx = instr_idx_lp;
    else if (|attr_vec) inc_idx = reason_idx;
    else                inc_idx = unknown_idx_lp;
  end

  // Decode the increment target and saturation state per counter
  always_comb begin
    for (int k = 0; k < num_cnt_lp; k++) begin
      inc_hot[k] = count_en && (inc_idx == addr_width_lp'(k));
      sat[k]     = (cnt_q[k] == cnt_max_lp);
    end
  end

  // Next counter values: clear dominates, saturated counters hold
  always_comb begin
    for (int k = 0; k < num_cnt_lp; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clear_i) begin
        cnt_d[k] = '0;
      end else if (inc_hot[k] && !sat[k]) begin
        cnt_d[k] = cnt_q[k] + cnt_t'(1);
      end
    end
  end

  // Read mux returns pre-update counter values; out-of-range indices read 0
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < num_cnt_lp; k++) begin
      if (rd_addr_i == addr_width_lp'(k)) rd_sel = cnt_q[k];
    end
    rd_v_d    = rd_v_i;
    rd_data_d = rd_v_i ? rd_sel : rd_data_q;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      // NOTE: the counter bank is plain flops, not a RAM macro, so it can and must be reset here with the rest of the state.
      for (int i = 0; i < num_stages_p; i++) stage_q[i] <= '0;
      for (int k = 0; k < num_cnt_lp; k++)   cnt_q[k]   <= '0;
      commit_q  <= 1'b0;
      rd_v_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
      for (int i = 0; i < num_stages_p; i++) stage_q[i] <= stage_d[i];
      for (int k = 0; k < num_cnt_lp; k++)   cnt_q[k]   <= cnt_d[k];
      commit_q  <= commit_d;
      rd_v_q    <= rd_v_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_v_o    = rd_v_q;
  assign rd_data_o = rd_data_q;

`ifdef BP_STALL_ATTR_OVF_EN
  logic [num_cnt_lp-1:0] ovf_q, ovf_d;

  // Sticky overflow: set when a saturated counter is asked to increment
  always_comb begin
    if (clear_i) ovf_d = '0;
    else         ovf_d = ovf_q | (inc_hot & sat);
  end

  // Overflow flag register
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) ovf_q <= '0;
    else           ovf_q <= ovf_d;
  end

  assign ovf_o     = ovf_q;
  assign ovf_any_o = |ovf_q;
`endif

endmodule

// File: doc/bp_be_stall_attribution_counters.md
Name: bp_be_stall_attribution_counters

Overview:
Synthesizable, parametrised successor to the per-cycle stall trace profiler for the BlackParrot backend. It takes per-stage stall-reason event vectors and shifts them down an attribution pipeline. Each enabled cycle is classified as instruction commit, one stall reason, or unknown. The block keeps a saturating counter per class, readable through a registered read port. Counters replace file output so attribution can run in emulation and silicon.

Parameters:
num_reasons_p, 22, number of stall-reason bits per stage.
num_stages_p, 8, attribution pipeline depth; must be >= 1.
cnt_width_p, 32, width of each counter.
lo_to_hi_p, 1, priority direction: 1 = lowest reason index wins, 0 = highest wins.
num_cnt_lp (localparam), num_reasons_p+2, total counters.
addr_width_lp (localparam), clog2(num_cnt_lp), read address width.

Ports:
clk_i  in  1  clock, rising edge.
reset_li  in  1  reset, asynchronous, active-low.
en_i  in  1  counting enable.
freeze_i  in  1  core freeze; suppresses counting when high.
clear_i  in  1  synchronous clear of all counters.
event_i  in  num_stages_p*num_reasons_p  stall events; slice i = stage i, bit j = reason j.
commit_v_i  in  1  instruction committed this cycle.
rd_v_i  in  1  read request.
rd_addr_i  in  addr_width_lp  counter index.
rd_v_o  out  1  read data valid.
rd_data_o  out  cnt_width_p  counter value.

Behaviour:
- Reset (reset_li=0, async): stage registers, commit register, all counters, rd_v_o and rd_data_o go to 0 immediately. They stay 0 until the first rising edge after reset deasserts. Reset mid-operation discards in-flight attribution.
- Stage pipeline, every cycle regardless of en_i:
  - stage_n[0] = event_i[0]
  - stage_n[i] = stage_r[i-1] | event_i[i] for i>0
  - The attributed vector is stage_r[num_stages_p-1].
- Commit alignment: commit_v_i is registered once to commit_r. Classification uses commit_r with the attributed vector.
- Counter indices: 0..num_reasons_p-1 are reasons, num_reasons_p is instr, num_reasons_p+1 is unknown.
- Classification, applied when en_i=1 and freeze_i=0, exactly one counter incremented per cycle:
  - commit_r=1: increment instr.
  - else attributed vector nonzero: increment the priority-encoded reason, with direction set by lo_to_hi_p.
  - else: increment unknown.
- Invariant: with no saturation or clear, the sum of all counters equals the number of counted cycles.
- Saturation: a counter at 2^cnt_width_p-1 holds that value. Other counters are unaffected.
- clear_i=1: all counters become 0 next cycle. Clear wins over a same-cycle increment, so the result is 0, not 1. The stage pipeline is not cleared.
- Read: rd_v_i sampled at edge N gives rd_v_o=1 and rd_data_o = counter value before the edge-N update, valid during cycle N+1.
  - No backpressure; back-to-back reads are allowed.
  - When rd_v_o=0, rd_data_o holds its last value.
  - rd_addr_i >= num_cnt_lp returns 0 with rd_v_o=1.

Optional Feature:
Macro BP_STALL_ATTR_OVF_EN.
- Defined: adds output ovf_o, width num_cnt_lp, one sticky bit per counter.
  - A bit sets on the cycle its counter would increment while already saturated.
  - A bit clears only on reset_li or clear_i.
  - Adds output ovf_any_o, the OR of ovf_o.
- Undefined: neither port exists and saturation is silent.

Test Plan:
- Reset, en_i=1, commit_v_i=1 for 10 cycles, events 0, then commit 0 -> read addr 22 returns 10; addr 23 (unknown) counts the remaining cycles.
- event_i[0] bit 5 pulsed for 1 cycle, commit 0, num_stages_p=8 -> reason 5 incremented exactly once, 8 cycles after the pulse. Read addr 5 returns 1.
- Reasons 3 and 9 both in the attributed vector -> lo_to_hi_p=1 increments counter 3; lo_to_hi_p=0 increments counter 9.
- cnt_width_p=4, 20 commit cycles -> addr 22 reads 15. With BP_STALL_ATTR_OVF_EN, ovf_o[22]=1 from the 16th commit onward; ovf_any_o=1.
- clear_i asserted in the same cycle as a commit increment -> read addr 22 next cycle returns 0. A read issued in the clear cycle returns the pre-clear value.
- reset_li driven low mid-run (asynchronously, between edges) -> rd_v_o, rd_data_o and all counters read 0. Events in flight before reset never increment any counter.
